sdram_request_arbiter: RTL and testbench

Shares the single SDRAM command sequencer between three requesters: the periodic auto-refresh requester (level request / pulse acknowledge), a host read port and a host write port (valid/ready). Refresh has absolute priority at each arbitration point. Read and write alternate round-robin. A command in flight is never preempted. Sits between the refresh counter and the host ports on one side, and the SDRAM command FSM on the other.

---
 rtl/sdram_arbiter_pkg.sv | 24 ++
 rtl/sdram_request_arbiter.sv | 143 ++++++++++++++
 tb/tb_sdram_request_arbiter.sv | 541 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared types for the SDRAM request arbiter.
// Command opcodes, arbiter FSM states and host grant identifiers.
package sdram_arbiter_pkg;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'd0,
        CMD_REFRESH = 2'd1,
        CMD_READ    = 2'd2,
        CMD_WRITE   = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } arb_state_t;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

endpackage

// File: rtl/sdram_request_arbiter.sv
// Arbitrates refresh, host read and host write onto one SDRAM sequencer.
// Refresh has priority; read/write alternate on ties; no preemption.
module sdram_request_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = 24,
    parameter int DATA_WIDTH      = 16,
    parameter int REFRESH_HOLDOFF = 3,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  refresh_request,
    output logic                  refresh_response,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [1:0]            cmd_op,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  cmd_done,
    input  logic [DATA_WIDTH-1:0] cmd_rdata,
    output logic                  busy,
    output logic                  timeout_error
);

    localparam int HW = $clog2(REFRESH_HOLDOFF + 2);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t    state_q;
    cmd_op_t       op_q;
    grant_t        last_q;
    logic [HW-1:0] holdoff_q;
    logic [WW-1:0] wait_q;

    logic idle;
    logic ref_win;
    logic rd_win;
    logic wr_win;
    logic cmd_finish;

    assign idle    = (state_q == ST_IDLE);
    assign ref_win = idle && refresh_request && (holdoff_q == '0);
    assign rd_win  = idle && !ref_win && rd_valid
                     && (!wr_valid || last_q == GRANT_WRITE);
    assign wr_win  = idle && !ref_win && wr_valid
                     && (!rd_valid || last_q == GRANT_READ);

    assign rd_ready = rd_win;
    assign wr_ready = wr_win;
    assign busy     = !idle;
    assign cmd_op   = op_q;

    assign cmd_finish = ((state_q == ST_ISSUE) && cmd_ready && cmd_done)
                      || ((state_q == ST_WAIT) && cmd_done);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            op_q             <= CMD_NOP;
            last_q           <= GRANT_WRITE;
            holdoff_q        <= '0;
            wait_q           <= '0;
            cmd_valid        <= 1'b0;
            cmd_addr         <= '0;
            cmd_wdata        <= '0;
            refresh_response <= 1'b0;
            rd_data_valid    <= 1'b0;
            rd_data          <= '0;
            timeout_error    <= 1'b0;
        end else begin
            refresh_response <= 1'b0;
            rd_data_valid    <= 1'b0;
            wait_q           <= '0;
            if (holdoff_q != '0)
                holdoff_q <= holdoff_q - HW'(1);

            // Completion pulses land in the DONE cycle that follows.
            if (cmd_finish) begin
                refresh_response <= (op_q == CMD_REFRESH);
                rd_data_valid    <= (op_q == CMD_READ);
                if (op_q == CMD_READ)
                    rd_data <= cmd_rdata;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (ref_win) begin
                        op_q      <= CMD_REFRESH;
                        cmd_addr  <= '0;
                        cmd_wdata <= '0;
                        cmd_valid <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end else if (rd_win) begin
                        op_q      <= CMD_READ;
                        cmd_addr  <= rd_addr;
                        cmd_wdata <= '0;
                        cmd_valid <= 1'b1;
                        last_q    <= GRANT_READ;
                        state_q   <= ST_ISSUE;
                    end else if (wr_win) begin
                        op_q      <= CMD_WRITE;
                        cmd_addr  <= wr_addr;
                        cmd_wdata <= wr_data;
                        cmd_valid <= 1'b1;
                        last_q    <= GRANT_WRITE;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state_q   <= cmd_done ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_q <= wait_q;
                    if (wait_q != WW'(TIMEOUT_CYCLES))
                        wait_q <= wait_q + WW'(1);
                    if (wait_q == WW'(TIMEOUT_CYCLES - 1))
                        timeout_error <= 1'b1;
                    if (cmd_done)
                        state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (op_q == CMD_REFRESH)
                        holdoff_q <= HW'(REFRESH_HOLDOFF);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_request_arbiter.sv
// Testbench for sdram_request_arbiter: vector table, directed corner
// sequences and a randomized run against a timing-rule reference model.
module tb_sdram_request_arbiter;
    import sdram_arbiter_pkg::*;

    localparam int AW   = 24;
    localparam int DW   = 16;
    localparam int HOLD = 3;
    localparam int TMO  = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          refresh_request;
    logic          refresh_response;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          cmd_done;
    logic [DW-1:0] cmd_rdata;
    logic          busy;
    logic          timeout_error;

    int tests  = 0;
    int failed = 0;

    sdram_request_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .REFRESH_HOLDOFF (HOLD),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .refresh_request  (refresh_request),
        .refresh_response (refresh_response),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .rd_data_valid    (rd_data_valid),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_addr         (cmd_addr),
        .cmd_wdata        (cmd_wdata),
        .cmd_done         (cmd_done),
        .cmd_rdata        (cmd_rdata),
        .busy             (busy),
        .timeout_error    (timeout_error)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Move to 1ns after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        refresh_request = 1'b0;
        rd_valid  = 1'b0;
        rd_addr   = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        cmd_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic    rf;
        logic    rv;
        logic    wv;
        logic    erd;
        logic    ewr;
        cmd_op_t eop;
    } vec_t;

    vec_t vt[7];

    task automatic run_table();
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CMD_NOP};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, CMD_READ};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, CMD_WRITE};
        vt[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, CMD_READ};
        vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, CMD_REFRESH};
        vt[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CMD_REFRESH};
        vt[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, CMD_REFRESH};
        for (int i = 0; i < 7; i++) begin
            do_reset();
            chk($sformatf("tbl%0d reset busy", i), busy, 0);
            chk($sformatf("tbl%0d reset op", i), cmd_op, CMD_NOP);
            refresh_request = vt[i].rf;
            rd_valid = vt[i].rv;
            wr_valid = vt[i].wv;
            rd_addr  = AW'(24'h100 + i);
            wr_addr  = AW'(24'h200 + i);
            wr_data  = DW'(16'hA000 + i);
            #1;
            chk($sformatf("tbl%0d rd_ready", i), rd_ready, vt[i].erd);
            chk($sformatf("tbl%0d wr_ready", i), wr_ready, vt[i].ewr);
            step();
            clear_inputs();
            #1;
            chk($sformatf("tbl%0d cmd_valid", i), cmd_valid,
                vt[i].eop != CMD_NOP);
            chk($sformatf("tbl%0d cmd_op", i), cmd_op, vt[i].eop);
            if (vt[i].eop == CMD_READ)
                chk($sformatf("tbl%0d addr", i), cmd_addr, 24'h100 + i);
            if (vt[i].eop == CMD_WRITE) begin
                chk($sformatf("tbl%0d addr", i), cmd_addr, 24'h200 + i);
                chk($sformatf("tbl%0d wdata", i), cmd_wdata, 16'hA000 + i);
            end
            cmd_ready = 1'b1;
            cmd_done  = 1'b1;
            step();
            clear_inputs();
            #1;
            chk($sformatf("tbl%0d done busy", i), busy,
                vt[i].eop != CMD_NOP);
            chk($sformatf("tbl%0d rsp", i), refresh_response,
                vt[i].eop == CMD_REFRESH);
        end
    endtask

    task automatic seq_refresh_timing();
        do_reset();
        refresh_request = 1'b1;
        step();
        #1;
        chk("ref T+1 cmd_valid", cmd_valid, 1);
        chk("ref T+1 op", cmd_op, CMD_REFRESH);
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        #1;
        chk("ref T+2 cmd_valid", cmd_valid, 0);
        chk("ref T+2 rsp", refresh_response, 0);
        step();
        #1;
        chk("ref T+3 rsp", refresh_response, 0);
        step();
        cmd_done = 1'b1;
        #1;
        chk("ref T+4 rsp", refresh_response, 0);
        step();
        cmd_done = 1'b0;
        #1;
        chk("ref T+5 rsp", refresh_response, 1);
        step();
        #1;
        chk("ref T+6 rsp", refresh_response, 0);
        chk("ref T+6 busy", busy, 0);
        step();
        #1;
        chk("ref T+7 busy", busy, 0);
        step();
        refresh_request = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("ref no second %0d", k), cmd_valid, 0);
            step();
        end
    endtask

    task automatic seq_alternate();
        do_reset();
        rd_valid = 1'b1;
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("alt%0d rd_ready", i), rd_ready, i % 2 == 0);
            chk($sformatf("alt%0d wr_ready", i), wr_ready, i % 2 == 1);
            step();
            #1;
            chk($sformatf("alt%0d op", i), cmd_op,
                (i % 2 == 0) ? CMD_READ : CMD_WRITE);
            cmd_ready = 1'b1;
            cmd_done  = 1'b1;
            step();
            cmd_ready = 1'b0;
            cmd_done  = 1'b0;
            step();
        end
        clear_inputs();
    endtask

    task automatic seq_read_then_refresh();
        do_reset();
        rd_valid = 1'b1;
        rd_addr  = 24'h00ABCD;
        #1;
        chk("rr rd_ready", rd_ready, 1);
        step();
        rd_valid  = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 24'h000777;
        wr_data   = 16'h1234;
        cmd_ready = 1'b1;
        #1;
        chk("rr op read", cmd_op, CMD_READ);
        chk("rr addr", cmd_addr, 24'h00ABCD);
        chk("rr wr held", wr_ready, 0);
        step();
        cmd_ready = 1'b0;
        refresh_request = 1'b1;
        #1;
        chk("rr wait wr_ready", wr_ready, 0);
        step();
        cmd_done  = 1'b1;
        cmd_rdata = 16'hBEEF;
        step();
        cmd_done  = 1'b0;
        cmd_rdata = '0;
        #1;
        chk("rr rd_data_valid", rd_data_valid, 1);
        chk("rr rd_data", rd_data, 16'hBEEF);
        step();
        #1;
        chk("rr rdv one cycle", rd_data_valid, 0);
        chk("rr write held off", wr_ready, 0);
        step();
        #1;
        chk("rr refresh next", cmd_op, CMD_REFRESH);
        cmd_ready = 1'b1;
        cmd_done  = 1'b1;
        step();
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        refresh_request = 1'b0;
        #1;
        chk("rr rsp", refresh_response, 1);
        step();
        #1;
        chk("rr write served", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        #1;
        chk("rr op write", cmd_op, CMD_WRITE);
        chk("rr wdata", cmd_wdata, 16'h1234);
        cmd_ready = 1'b1;
        cmd_done  = 1'b1;
        step();
        clear_inputs();
        step();
    endtask

    task automatic seq_refresh_vs_read();
        do_reset();
        refresh_request = 1'b1;
        rd_valid = 1'b1;
        #1;
        chk("rvr rd_ready low", rd_ready, 0);
        step();
        #1;
        chk("rvr op", cmd_op, CMD_REFRESH);
        cmd_ready = 1'b1;
        cmd_done  = 1'b1;
        step();
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        refresh_request = 1'b0;
        #1;
        chk("rvr rsp", refresh_response, 1);
        chk("rvr rd_ready in done", rd_ready, 0);
        step();
        #1;
        chk("rvr read granted", rd_ready, 1);
        step();
        rd_valid = 1'b0;
        #1;
        chk("rvr op read", cmd_op, CMD_READ);
        cmd_ready = 1'b1;
        cmd_done  = 1'b1;
        step();
        clear_inputs();
        step();
    endtask

    task automatic seq_timeout();
        do_reset();
        wr_valid = 1'b1;
        step();
        wr_valid  = 1'b0;
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        #1;
        chk("tmo wait1", timeout_error, 0);
        for (int j = 2; j <= TMO; j++) begin
            step();
            #1;
            chk($sformatf("tmo wait%0d", j), timeout_error, 0);
        end
        step();
        #1;
        chk("tmo set", timeout_error, 1);
        chk("tmo still busy", busy, 1);
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
        step();
        #1;
        chk("tmo sticky", timeout_error, 1);
        chk("tmo idle", busy, 0);
        reset = 1'b1;
        step();
        #1;
        chk("tmo cleared", timeout_error, 0);
        chk("tmo reset idle", busy, 0);
        reset = 1'b0;
    endtask

    task automatic seq_reset_in_wait();
        do_reset();
        rd_valid = 1'b1;
        rd_addr  = 24'h123456;
        step();
        rd_valid  = 1'b0;
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset     = 1'b0;
        cmd_done  = 1'b1;
        cmd_rdata = 16'h5555;
        #1;
        chk("rst cmd_valid", cmd_valid, 0);
        chk("rst cmd_op", cmd_op, CMD_NOP);
        chk("rst cmd_addr", cmd_addr, 0);
        chk("rst cmd_wdata", cmd_wdata, 0);
        chk("rst busy", busy, 0);
        chk("rst rd_data", rd_data, 0);
        chk("rst rdv", rd_data_valid, 0);
        chk("rst rsp", refresh_response, 0);
        chk("rst tmo", timeout_error, 0);
        chk("rst rd_ready", rd_ready, 0);
        chk("rst wr_ready", wr_ready, 0);
        step();
        cmd_done  = 1'b0;
        cmd_rdata = '0;
        #1;
        chk("rst no rdv", rd_data_valid, 0);
        chk("rst stays idle", busy, 0);
        step();
        #1;
        chk("rst no rdv 2", rd_data_valid, 0);
    endtask

    // Reference model built from the timing rules: a grant at cycle g offers
    // the command from g+1 until accepted; completion accepted at d gives
    // its pulse at d+1 and idles at d+2; refresh is eligible again HOLD
    // cycles after that idle cycle.
    task automatic run_random(input int ncycles);
        int      free_at;
        int      ref_ok_at;
        int      pulse_at;
        int      ref_drop_at;
        int      dly;
        bit      last_rd;
        bit      offered;
        bit      waiting;
        bit      idle;
        bit      ref_w;
        bit      rd_w;
        bit      wr_w;
        cmd_op_t pulse_op;
        cmd_op_t e_op;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [DW-1:0] pulse_data;
        do_reset();
        free_at = 0;
        ref_ok_at = 0;
        pulse_at = -1;
        ref_drop_at = -1;
        dly = 0;
        last_rd = 1'b0;
        offered = 1'b0;
        waiting = 1'b0;
        pulse_op = CMD_NOP;
        pulse_data = '0;
        e_op = CMD_NOP;
        e_addr = '0;
        e_wdata = '0;
        for (int c = 0; c < ncycles; c++) begin
            if (!rd_valid && $urandom_range(3) == 0) begin
                rd_valid = 1'b1;
                rd_addr  = AW'($urandom);
            end
            if (!wr_valid && $urandom_range(3) == 0) begin
                wr_valid = 1'b1;
                wr_addr  = AW'($urandom);
                wr_data  = DW'($urandom);
            end
            if (ref_drop_at >= 0 && c >= ref_drop_at) begin
                refresh_request = 1'b0;
                ref_drop_at = -1;
            end else if (!refresh_request && $urandom_range(15) == 0)
                refresh_request = 1'b1;
            cmd_rdata = DW'($urandom);
            if (offered) begin
                cmd_ready = ($urandom_range(1) == 1);
                cmd_done  = cmd_ready && ($urandom_range(2) == 0);
                dly = $urandom_range(3);
            end else if (waiting) begin
                cmd_ready = ($urandom_range(1) == 1);
                cmd_done  = (dly == 0);
                dly--;
            end else begin
                cmd_ready = ($urandom_range(1) == 1);
                cmd_done  = ($urandom_range(5) == 0);
            end
            #1;
            idle  = (c >= free_at);
            ref_w = idle && refresh_request && (c >= ref_ok_at);
            rd_w  = idle && !ref_w && rd_valid && (!wr_valid || !last_rd);
            wr_w  = idle && !ref_w && wr_valid && (!rd_valid || last_rd);
            chk("rnd rd_ready", rd_ready, rd_w);
            chk("rnd wr_ready", wr_ready, wr_w);
            chk("rnd busy", busy, !idle);
            chk("rnd cmd_valid", cmd_valid, offered);
            if (offered) begin
                chk("rnd cmd_op", cmd_op, e_op);
                chk("rnd cmd_addr", cmd_addr, e_addr);
                chk("rnd cmd_wdata", cmd_wdata, e_wdata);
            end
            chk("rnd rsp", refresh_response,
                c == pulse_at && pulse_op == CMD_REFRESH);
            chk("rnd rdv", rd_data_valid,
                c == pulse_at && pulse_op == CMD_READ);
            if (c == pulse_at && pulse_op == CMD_READ)
                chk("rnd rd_data", rd_data, pulse_data);
            if (c == pulse_at && pulse_op == CMD_REFRESH)
                ref_drop_at = c + 1 + $urandom_range(3);
            chk("rnd timeout", timeout_error, 0);
            if (offered && cmd_ready) begin
                offered = 1'b0;
                waiting = !cmd_done;
            end else if (waiting && cmd_done) begin
                waiting = 1'b0;
            end else if (!offered && !waiting && idle) begin
                cmd_done = 1'b0;
            end
            if (!offered && !waiting && !idle && cmd_done
                && pulse_at != c + 1 && c + 1 < free_at
                && free_at > 1000000) begin
                pulse_at   = c + 1;
                pulse_op   = e_op;
                pulse_data = cmd_rdata;
                free_at    = c + 2;
                if (e_op == CMD_REFRESH)
                    ref_ok_at = c + 2 + HOLD;
            end
            if (ref_w || rd_w || wr_w) begin
                free_at = 1 << 30;
                offered = 1'b1;
                waiting = 1'b0;
                if (ref_w) begin
                    e_op = CMD_REFRESH;
                    e_addr = '0;
                    e_wdata = '0;
                end else if (rd_w) begin
                    e_op = CMD_READ;
                    e_addr = rd_addr;
                    e_wdata = '0;
                    last_rd = 1'b1;
                end else begin
                    e_op = CMD_WRITE;
                    e_addr = wr_addr;
                    e_wdata = wr_data;
                    last_rd = 1'b0;
                end
            end
            step();
            if (rd_w)
                rd_valid = 1'b0;
            if (wr_w)
                wr_valid = 1'b0;
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        run_table();
        seq_refresh_timing();
        seq_alternate();
        seq_read_then_refresh();
        seq_refresh_vs_read();
        seq_timeout();
        seq_reset_in_wait();
        run_random(3000);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
